// File: rtl/adder_pkg.sv
// Shared types for the pipelined add/subtract unit: operation encoding and NZVC flags.
package adder_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_ADC = 2'd2,
      OP_SBC = 2'd3
   } op_t;

   typedef struct packed {
      logic n;
      logic z;
      logic v;
      logic c;
   } flags_t;

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
interface pipelined_adder_if #(
   parameter int unsigned WIDTH = 64
);
   import adder_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   op_t              in_op;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   flags_t           out_flags;

   modport master (
      output in_valid, in_a, in_b, in_op, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_flags
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_flags
   );

endinterface

// File: rtl/adder_stage.sv
// One CHUNK-bit slice of the carry chain; also exposes the carry into its top bit.
module adder_stage #(
   parameter int unsigned CHUNK = 16
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb_in
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
   // Carry into the top bit recovered from the top-bit sum equation.
   assign c_msb_in = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract resolved one CHUNK per stage, carry registered between stages,
// NZVC flags formed in the last stage; whole pipe advances when the output is free.
module pipelined_adder #(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned STAGES = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   pipelined_adder_if.slave  bus
);
   import adder_pkg::*;

   localparam int unsigned CHUNK = WIDTH / STAGES;

   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] carry_q;
   logic [WIDTH-1:0]  a_q   [STAGES];
   logic [WIDTH-1:0]  b_q   [STAGES];
   logic [WIDTH-1:0]  sum_q [STAGES];
   flags_t            flags_q;
   flags_t            flags_d;

   logic [WIDTH-1:0]  src_a   [STAGES];
   logic [WIDTH-1:0]  src_b   [STAGES];
   logic [WIDTH-1:0]  src_sum [STAGES];
   logic [WIDTH-1:0]  nxt_sum [STAGES];
   logic              src_c   [STAGES];
   logic              src_v   [STAGES];
   logic              chunk_cout [STAGES];
   logic              last_msb_in;

   logic              advance;
   logic [WIDTH-1:0]  b_prep;
   logic              cin_prep;
   logic              unused_tail;

   assign advance      = !valid_q[STAGES-1] || bus.out_ready;
   assign bus.in_ready = advance;

   always_comb begin
      b_prep   = bus.in_b;
      cin_prep = 1'b0;
      case (bus.in_op)
         OP_ADD:  ;
         OP_SUB:  begin b_prep = ~bus.in_b; cin_prep = 1'b1;       end
         OP_ADC:  cin_prep = bus.in_cin;
         OP_SBC:  begin b_prep = ~bus.in_b; cin_prep = bus.in_cin; end
         default: ;
      endcase
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [CHUNK-1:0] chunk_sum;
      logic             msb_in;
      logic [WIDTH-1:0] merged;

      if (k == 0) begin : g_src
         assign src_a[k]   = bus.in_a;
         assign src_b[k]   = b_prep;
         assign src_c[k]   = cin_prep;
         assign src_v[k]   = bus.in_valid;
         assign src_sum[k] = '0;
      end else begin : g_src
         // Skew registers carry the not-yet-added upper chunks forward untouched.
         assign src_a[k]   = a_q[k-1];
         assign src_b[k]   = b_q[k-1];
         assign src_c[k]   = carry_q[k-1];
         assign src_v[k]   = valid_q[k-1];
         assign src_sum[k] = sum_q[k-1];
      end

      adder_stage #(.CHUNK(CHUNK)) u_stage (
         .a        (src_a[k][k*CHUNK +: CHUNK]),
         .b        (src_b[k][k*CHUNK +: CHUNK]),
         .cin      (src_c[k]),
         .sum      (chunk_sum),
         .cout     (chunk_cout[k]),
         .c_msb_in (msb_in)
      );

      always_comb begin
         merged = src_sum[k];
         merged[k*CHUNK +: CHUNK] = chunk_sum;
      end
      assign nxt_sum[k] = merged;

      if (k == STAGES - 1) begin : g_last
         assign last_msb_in = msb_in;
      end else begin : g_mid
         logic unused_msb_in;
         assign unused_msb_in = msb_in;
      end
   end

   always_comb begin
      flags_d   = '0;
      flags_d.n = nxt_sum[STAGES-1][WIDTH-1];
      flags_d.z = (nxt_sum[STAGES-1] == '0);
      flags_d.v = last_msb_in ^ chunk_cout[STAGES-1];
      flags_d.c = chunk_cout[STAGES-1];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         carry_q <= '0;
         flags_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            sum_q[k] <= '0;
         end
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= src_v[k];
            carry_q[k] <= chunk_cout[k];
            a_q[k]     <= src_a[k];
            b_q[k]     <= src_b[k];
            sum_q[k]   <= nxt_sum[k];
         end
         flags_q <= flags_d;
      end
   end

   // Last stage's operand/carry copies feed nothing; synthesis trims them.
   assign unused_tail = carry_q[STAGES-1] ^ (^a_q[STAGES-1]) ^ (^b_q[STAGES-1]);

   assign bus.out_valid = valid_q[STAGES-1];
   assign bus.out_sum   = sum_q[STAGES-1];
   assign bus.out_flags = flags_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed corner cases, reset, stall and random stream.
module tb_pipelined_adder;
   import adder_pkg::*;

   localparam int unsigned W = 64;
   localparam int unsigned S = 4;

   typedef struct packed {
      logic [3:0]   flags;
      logic [W-1:0] sum;
   } exp_t;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;

   int n_checks     = 0;
   int n_fail       = 0;
   int result_count = 0;
   int stall_seen   = 0;

   exp_t         exp_q[$];
   logic         hold_prev = 1'b0;
   logic [W-1:0] prev_sum;
   logic [3:0]   prev_flags;
   logic [W-1:0] got_sum;
   logic [3:0]   got_flags;

   pipelined_adder_if #(.WIDTH(W)) bus ();

   pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: plain wide arithmetic plus textbook signed-overflow rule.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input op_t op,
                                  input logic cin);
      logic [W-1:0] bb;
      logic         c0;
      logic [W:0]   full;
      exp_t         r;
      bb   = (op == OP_SUB || op == OP_SBC) ? ~b : b;
      c0   = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : cin;
      full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
      r.sum   = full[W-1:0];
      r.flags = {full[W-1], (full[W-1:0] == '0),
                 (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]), full[W]};
      return r;
   endfunction

   function automatic logic [W-1:0] rand_operand();
      logic [W-1:0] v;
      v = {$urandom, $urandom};
      case ($urandom_range(0, 7))
         0: v = '0;
         1: v = '1;
         2: v = {1'b0, {(W-1){1'b1}}};
         3: v = {1'b1, {(W-1){1'b0}}};
         default: ;
      endcase
      return v;
   endfunction

   // One cycle: drive after the falling edge, then judge what the next rising edge will transfer.
   task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input op_t op, input logic cin, input logic ordy, output logic accepted);
      exp_t e;
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_op     = op;
      bus.in_cin    = cin;
      bus.out_ready = ordy;
      #1;
      if (hold_prev) begin
         check_eq("hold_valid", W'(bus.out_valid), W'(1));
         check_eq("hold_sum", bus.out_sum, prev_sum);
         check_eq("hold_flags", W'(bus.out_flags), W'(prev_flags));
      end
      if (bus.out_valid && !bus.out_ready) begin
         stall_seen++;
         check_eq("stall_in_ready", W'(bus.in_ready), W'(0));
      end
      if (bus.out_valid && bus.out_ready) begin
         result_count++;
         got_sum   = bus.out_sum;
         got_flags = bus.out_flags;
         if (exp_q.size() == 0) begin
            check_eq("spurious_result", W'(bus.out_valid), W'(0));
         end else begin
            e = exp_q.pop_front();
            check_eq("sb_sum", bus.out_sum, e.sum);
            check_eq("sb_flags", W'(bus.out_flags), W'(e.flags));
         end
      end
      accepted = v && bus.in_ready;
      if (accepted) exp_q.push_back(model(a, b, op, cin));
      hold_prev  = bus.out_valid && !bus.out_ready;
      prev_sum   = bus.out_sum;
      prev_flags = bus.out_flags;
   endtask

   task automatic directed(input string tag, input op_t op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic cin,
                           input logic [W-1:0] exp_sum, input logic [3:0] exp_flags);
      int   n0;
      int   waited;
      logic acc;
      n0 = result_count;
      step(1'b1, a, b, op, cin, 1'b1, acc);
      check_eq({tag, "_acc"}, W'(acc), W'(1));
      waited = 0;
      while (result_count == n0 && waited < 20) begin
         step(1'b0, '0, '0, OP_ADD, 1'b0, 1'b1, acc);
         waited++;
      end
      check_eq({tag, "_latency"}, W'(waited), W'(S));
      check_eq({tag, "_sum"}, got_sum, exp_sum);
      check_eq({tag, "_flags"}, W'(got_flags), W'(exp_flags));
   endtask

   initial begin : main
      logic         acc;
      logic         have_op;
      logic [W-1:0] ra, rb;
      op_t          rop;
      logic         rcin;
      int           n0, sent, acc_cnt;

      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_op     = OP_ADD;
      bus.in_cin    = 1'b0;
      bus.out_ready = 1'b1;

      #1 reset_n = 1'b0;
      #1;
      check_eq("reset_out_valid", W'(bus.out_valid), W'(0));
      check_eq("reset_in_ready", W'(bus.in_ready), W'(1));
      check_eq("reset_out_sum", bus.out_sum, '0);
      check_eq("reset_out_flags", W'(bus.out_flags), W'(0));
      repeat (3) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;

      // flags packed as {n,z,v,c}
      directed("add_1_1", OP_ADD, 64'd1, 64'd1, 1'b0, 64'd2, 4'b0000);
      directed("add_wrap", OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b0101);
      directed("sub_0_1", OP_SUB, 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);
      directed("add_ovf", OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
               64'h8000_0000_0000_0000, 4'b1010);
      directed("sbc_5_3", OP_SBC, 64'd5, 64'd3, 1'b0, 64'd1, 4'b0001);
      directed("adc_5_3", OP_ADC, 64'd5, 64'd3, 1'b1, 64'd9, 4'b0000);

      // Reset with three ops in flight and the first one already at the output.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, rand_operand(), rand_operand(), op_t'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'b0, acc);
      end
      step(1'b0, '0, '0, OP_ADD, 1'b0, 1'b0, acc);
      @(posedge clk);
      #2;
      check_eq("rst_pre_valid", W'(bus.out_valid), W'(1));
      reset_n = 1'b0;
      #1;
      check_eq("rst_out_valid", W'(bus.out_valid), W'(0));
      check_eq("rst_out_sum", bus.out_sum, '0);
      check_eq("rst_out_flags", W'(bus.out_flags), W'(0));
      check_eq("rst_in_ready", W'(bus.in_ready), W'(1));
      exp_q.delete();
      hold_prev = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;
      n0 = result_count;
      repeat (10) step(1'b0, '0, '0, OP_ADD, 1'b0, 1'b1, acc);
      check_eq("rst_no_result", W'(result_count - n0), W'(0));

      // Back-pressure: 8 ops, consumer stalls for 5 cycles starting at cycle 2.
      n0 = result_count;
      sent = 0;
      have_op = 1'b0;
      stall_seen = 0;
      for (int cyc = 0; cyc < 60 && (sent < 8 || result_count - n0 < 8); cyc++) begin
         if (sent < 8 && !have_op) begin
            ra = rand_operand();
            rb = rand_operand();
            rop = op_t'($urandom_range(0, 3));
            rcin = 1'($urandom_range(0, 1));
            have_op = 1'b1;
         end
         step(sent < 8, ra, rb, rop, rcin, !(cyc >= 2 && cyc < 7), acc);
         if (acc) begin
            sent++;
            have_op = 1'b0;
         end
      end
      check_eq("bp_sent", W'(sent), W'(8));
      check_eq("bp_results", W'(result_count - n0), W'(8));
      check_eq("bp_stalled", W'(stall_seen > 0), W'(1));
      check_eq("bp_queue_empty", W'(exp_q.size()), W'(0));

      // Full-rate random stream.
      n0 = result_count;
      acc_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         step(1'b1, rand_operand(), rand_operand(), op_t'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'b1, acc);
         if (acc) acc_cnt++;
      end
      for (int i = 0; i < int'(S); i++) step(1'b0, '0, '0, OP_ADD, 1'b0, 1'b1, acc);
      check_eq("tput_accepted", W'(acc_cnt), W'(100));
      check_eq("tput_results", W'(result_count - n0), W'(100));
      check_eq("final_queue_empty", W'(exp_q.size()), W'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
